ddr3_axi_resp_model: RTL and testbench



---
 rtl/ddr3_axi_resp_model.sv | 159 +++++++++++++++
 tb/tb_ddr3_axi_resp_model.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_axi_resp_model.sv
// ddr3_axi_resp_model
// Block-RAM backed stand-in for the DDR3 controller's user-side AXI port.
// Lets the AXI master and FIFO control path run without a memory device.
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   ddr_init_done                 memory ready, rises INIT_DELAY+1 cycles after reset
//   axi_aw*                       write address channel (addr in 16-bit units)
//   axi_wdata/wstrb               write beat data and byte enables
//   axi_wready/wusero_id/_last    beat-consume strobe, burst ID, last-beat flag
//   axi_ar*                       read address channel
//   axi_rdata/rid/rlast/rvalid    read beat stream (master always accepts)
//
// state  | meaning
// INIT   | counting down the init delay, requests ignored
// IDLE   | waiting for a request, round-robin on conflict
// WACC   | write address accepted (awready high)
// WBURST | consuming one write beat per cycle
// RACC   | read address accepted (arready high)
// RBURST | issuing one RAM read per cycle
// RDRAIN | emitting the final read beat

module ddr3_axi_resp_model #(
  parameter int MEM_AW     = 10,
  parameter int INIT_DELAY = 64
) (
  input  logic         clk,
  input  logic         rst,
  output logic         ddr_init_done,
  input  logic [27:0]  axi_awaddr,
  input  logic [3:0]   axi_awuser_id,
  input  logic [3:0]   axi_awlen,
  input  logic         axi_awvalid,
  output logic         axi_awready,
  input  logic [127:0] axi_wdata,
  input  logic [15:0]  axi_wstrb,
  output logic         axi_wready,
  output logic [3:0]   axi_wusero_id,
  output logic         axi_wusero_last,
  input  logic [27:0]  axi_araddr,
  input  logic [3:0]   axi_aruser_id,
  input  logic [3:0]   axi_arlen,
  input  logic         axi_arvalid,
  output logic         axi_arready,
  output logic [127:0] axi_rdata,
  output logic [3:0]   axi_rid,
  output logic         axi_rlast,
  output logic         axi_rvalid
);

  typedef enum logic [2:0] {INIT, IDLE, WACC, WBURST, RACC, RBURST, RDRAIN} state_t;

  state_t            state, state_nxt;
  logic [15:0]       init_cnt;
  logic [3:0]        cnt, cnt_nxt;
  logic [MEM_AW-1:0] ptr, ptr_nxt;
  logic              last_wr, last_wr_nxt;
  logic [3:0]        wid_nxt, rid_nxt;

  logic [127:0] mem [2**MEM_AW];

  // Upper address bits alias by design; sub-word bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_awaddr[27:MEM_AW+3], axi_awaddr[2:0],
                              axi_araddr[27:MEM_AW+3], axi_araddr[2:0]};

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ptr_nxt     = ptr;
    last_wr_nxt = last_wr;
    wid_nxt     = axi_wusero_id;
    rid_nxt     = axi_rid;
    case (state)
      INIT: if (init_cnt == 16'd0) state_nxt = IDLE;
      IDLE: begin
        // On conflict, the direction not served by the previous burst wins.
        if (axi_awvalid && (!axi_arvalid || !last_wr)) begin
          state_nxt   = WACC;
          ptr_nxt     = axi_awaddr[MEM_AW+2:3];
          cnt_nxt     = axi_awlen;
          wid_nxt     = axi_awuser_id;
          last_wr_nxt = 1'b1;
        end else if (axi_arvalid) begin
          state_nxt   = RACC;
          ptr_nxt     = axi_araddr[MEM_AW+2:3];
          cnt_nxt     = axi_arlen;
          rid_nxt     = axi_aruser_id;
          last_wr_nxt = 1'b0;
        end
      end
      WACC:   state_nxt = WBURST;
      WBURST: begin
        ptr_nxt = ptr + 1'b1;
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RACC:   state_nxt = RBURST;
      RBURST: begin
        ptr_nxt = ptr + 1'b1;
        if (cnt == 4'd0) state_nxt = RDRAIN;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RDRAIN:  state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= INIT;
      init_cnt        <= 16'(INIT_DELAY);
      cnt             <= 4'd0;
      ptr             <= '0;
      last_wr         <= 1'b0;
      ddr_init_done   <= 1'b0;
      axi_awready     <= 1'b0;
      axi_arready     <= 1'b0;
      axi_wready      <= 1'b0;
      axi_wusero_last <= 1'b0;
      axi_wusero_id   <= 4'd0;
      axi_rid         <= 4'd0;
      axi_rvalid      <= 1'b0;
      axi_rlast       <= 1'b0;
      axi_rdata       <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      last_wr <= last_wr_nxt;
      if (state == INIT) begin
        if (init_cnt == 16'd0) ddr_init_done <= 1'b1;
        else                   init_cnt      <= init_cnt - 16'd1;
      end
      // Handshake outputs are registered from the next state so they line
      // up with the cycle spent in that state.
      axi_awready     <= (state_nxt == WACC);
      axi_arready     <= (state_nxt == RACC);
      axi_wready      <= (state_nxt == WBURST);
      axi_wusero_last <= (state_nxt == WBURST) && (cnt_nxt == 4'd0);
      axi_wusero_id   <= wid_nxt;
      axi_rid         <= rid_nxt;
      // The read register is the RAM output stage: one cycle behind RBURST.
      axi_rvalid      <= (state == RBURST);
      axi_rlast       <= (state == RBURST) && (cnt == 4'd0);
      if (state == RBURST) axi_rdata <= mem[ptr];
    end
  end

  // Memory is deliberately not reset; a beat coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && state == WBURST) begin
      for (int i = 0; i < 16; i++) begin
        if (axi_wstrb[i]) mem[ptr][8*i +: 8] <= axi_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ddr3_axi_resp_model.sv
// Testbench for ddr3_axi_resp_model: directed scenarios plus randomized
// bursts checked against a word-array reference memory.
module tb_ddr3_axi_resp_model;
  localparam int MEM_AW     = 10;
  localparam int INIT_DELAY = 64;
  localparam int DEPTH      = 1 << MEM_AW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ddr_init_done;
  logic [27:0]  axi_awaddr = '0;
  logic [3:0]   axi_awuser_id = '0;
  logic [3:0]   axi_awlen = '0;
  logic         axi_awvalid = 1'b0;
  logic         axi_awready;
  logic [127:0] axi_wdata = '0;
  logic [15:0]  axi_wstrb = '0;
  logic         axi_wready;
  logic [3:0]   axi_wusero_id;
  logic         axi_wusero_last;
  logic [27:0]  axi_araddr = '0;
  logic [3:0]   axi_aruser_id = '0;
  logic [3:0]   axi_arlen = '0;
  logic         axi_arvalid = 1'b0;
  logic         axi_arready;
  logic [127:0] axi_rdata;
  logic [3:0]   axi_rid;
  logic         axi_rlast;
  logic         axi_rvalid;

  always #5 clk = ~clk;

  ddr3_axi_resp_model #(.MEM_AW(MEM_AW), .INIT_DELAY(INIT_DELAY)) dut (
    .clk(clk), .rst(rst), .ddr_init_done(ddr_init_done),
    .axi_awaddr(axi_awaddr), .axi_awuser_id(axi_awuser_id), .axi_awlen(axi_awlen),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_wusero_id(axi_wusero_id), .axi_wusero_last(axi_wusero_last),
    .axi_araddr(axi_araddr), .axi_aruser_id(axi_aruser_id), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rid(axi_rid), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid)
  );

  logic [127:0] ref_mem [DEPTH];
  logic [127:0] beat_data [16];
  logic [15:0]  beat_strb [16];
  int total  = 0;
  int passed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_init_done"}, ddr_init_done, 0);
    chk({tag, "_awready"},   axi_awready, 0);
    chk({tag, "_arready"},   axi_arready, 0);
    chk({tag, "_wready"},    axi_wready, 0);
    chk({tag, "_wlast"},     axi_wusero_last, 0);
    chk({tag, "_wid"},       axi_wusero_id, 0);
    chk({tag, "_rvalid"},    axi_rvalid, 0);
    chk({tag, "_rlast"},     axi_rlast, 0);
    chk({tag, "_rid"},       axi_rid, 0);
    chk({tag, "_rdata"},     axi_rdata, 0);
  endtask

  // Holds reset, releases it with an early write request pending, and checks
  // that ready appears exactly INIT_DELAY+1 cycles later with nothing accepted.
  task automatic do_reset_init();
    bit early_done, early_aw;
    rst = 1'b1;
    axi_awvalid = 1'b0;
    axi_arvalid = 1'b0;
    tick();
    tick();
    chk_outputs_zero("reset");
    axi_awaddr = 28'h40; axi_awlen = 4'd0; axi_awuser_id = 4'h1; axi_awvalid = 1'b1;
    rst = 1'b0;
    early_done = 0;
    early_aw = 0;
    for (int c = 1; c <= INIT_DELAY; c++) begin
      tick();
      if (ddr_init_done) early_done = 1;
      if (axi_awready) early_aw = 1;
    end
    chk("init_done_early", early_done, 0);
    chk("init_aw_ignored", early_aw, 0);
    tick();
    chk("init_done_rise", ddr_init_done, 1);
    chk("init_no_aw", axi_awready, 0);
    axi_awvalid = 1'b0;
  endtask

  task automatic wr_burst(input logic [27:0] addr, input logic [3:0] id,
                          input logic [3:0] len, input int abort_beat);
    int n, w;
    bit other;
    axi_awaddr = addr; axi_awuser_id = id; axi_awlen = len; axi_awvalid = 1'b1;
    n = 0;
    other = 0;
    while (axi_awready !== 1'b1 && n < 60) begin
      tick();
      n++;
      if (axi_arready) other = 1;
    end
    chk("aw_accept", axi_awready, 1);
    chk("aw_not_preceded_by_ar", other, 0);
    chk("aw_ar_exclusive", axi_arready, 0);
    axi_awvalid = 1'b0;
    w = int'(addr) / 8 % DEPTH;
    axi_wdata = beat_data[0];
    axi_wstrb = beat_strb[0];
    tick();
    for (int idx = 0; idx <= int'(len); idx++) begin
      if (idx == abort_beat) begin
        rst = 1'b1;
        tick();
        chk_outputs_zero("rst_mid");
        return;
      end
      chk("wready", axi_wready, 1);
      chk("wlast", axi_wusero_last, (idx == int'(len)));
      chk("wid", axi_wusero_id, id);
      for (int b = 0; b < 16; b++)
        if (beat_strb[idx][b]) ref_mem[(w + idx) % DEPTH][8*b +: 8] = beat_data[idx][8*b +: 8];
      tick();
      if (idx < int'(len)) begin
        axi_wdata = beat_data[idx+1];
        axi_wstrb = beat_strb[idx+1];
      end
    end
    chk("wready_end", axi_wready, 0);
  endtask

  task automatic rd_burst(input logic [27:0] addr, input logic [3:0] id, input logic [3:0] len);
    int n, r;
    bit other;
    axi_araddr = addr; axi_aruser_id = id; axi_arlen = len; axi_arvalid = 1'b1;
    n = 0;
    other = 0;
    while (axi_arready !== 1'b1 && n < 60) begin
      tick();
      n++;
      if (axi_awready) other = 1;
    end
    chk("ar_accept", axi_arready, 1);
    chk("ar_not_preceded_by_aw", other, 0);
    chk("ar_aw_exclusive", axi_awready, 0);
    axi_arvalid = 1'b0;
    r = int'(addr) / 8 % DEPTH;
    tick();
    chk("rvalid_gap", axi_rvalid, 0);
    tick();
    for (int i = 0; i <= int'(len); i++) begin
      chk("rvalid", axi_rvalid, 1);
      chk("rdata", axi_rdata, ref_mem[(r + i) % DEPTH]);
      chk("rlast", axi_rlast, (i == int'(len)));
      chk("rid", axi_rid, id);
      tick();
    end
    chk("rvalid_end", axi_rvalid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [27:0] a;
    logic [3:0]  l;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    do_reset_init();

    // Write/readback, data = beat index.
    for (int i = 0; i < 16; i++) begin beat_data[i] = 128'(i); beat_strb[i] = 16'hFFFF; end
    wr_burst(28'h40, 4'h2, 4'd15, -1);
    rd_burst(28'h40, 4'h6, 4'd15);

    // Strobe merge on a single word.
    beat_data[0] = '1; beat_strb[0] = 16'hFFFF;
    wr_burst(28'h100, 4'h1, 4'd0, -1);
    beat_data[0] = '0; beat_strb[0] = 16'h00FF;
    wr_burst(28'h100, 4'h1, 4'd0, -1);
    rd_burst(28'h100, 4'h1, 4'd0);

    // Wrap from the last word to word 0.
    beat_data[0] = 128'hAAAA_0000_0000_0000_0000_0000_0000_1023; beat_strb[0] = 16'hFFFF;
    beat_data[1] = 128'hBBBB_0000_0000_0000_0000_0000_0000_0000; beat_strb[1] = 16'hFFFF;
    wr_burst(28'(1023 << 3), 4'h4, 4'd1, -1);
    rd_burst(28'h0, 4'h4, 4'd0);
    rd_burst(28'(1023 << 3), 4'h4, 4'd1);

    // Conflicts after a read: write wins, twice in a row.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin beat_data[i] = {4{$urandom}}; beat_strb[i] = 16'hFFFF; end
      axi_araddr = 28'h200; axi_aruser_id = 4'd5; axi_arlen = 4'd3; axi_arvalid = 1'b1;
      wr_burst(28'h200, 4'd3, 4'd3, -1);
      rd_burst(28'h200, 4'd5, 4'd3);
    end

    // Conflict after a plain write: read wins.
    beat_data[0] = {4{$urandom}}; beat_strb[0] = 16'hFFFF;
    wr_burst(28'h300, 4'd7, 4'd0, -1);
    beat_data[0] = {4{$urandom}}; beat_strb[0] = 16'hF0F0;
    axi_awaddr = 28'h300; axi_awuser_id = 4'd9; axi_awlen = 4'd0; axi_awvalid = 1'b1;
    rd_burst(28'h300, 4'd8, 4'd0);
    wr_burst(28'h300, 4'd9, 4'd0, -1);
    rd_burst(28'h300, 4'd8, 4'd0);

    // Randomized bursts with aliased upper address bits.
    for (int k = 0; k < 24; k++) begin
      a = 28'($urandom);
      l = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          beat_data[i] = {$urandom, $urandom, $urandom, $urandom};
          beat_strb[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'hFFFF;
        end
        wr_burst(a, 4'($urandom), l, -1);
      end else begin
        rd_burst(a, 4'($urandom), l);
      end
    end

    // Reset during beat 5 of 16; beats 0..4 must survive re-init.
    for (int i = 0; i < 16; i++) begin beat_data[i] = 128'(32'hA0 + i); beat_strb[i] = 16'hFFFF; end
    wr_burst(28'(100 << 3), 4'hC, 4'd15, 5);
    do_reset_init();
    rd_burst(28'(100 << 3), 4'h2, 4'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
